// File: rtl/seg_scan_reader.sv
// Recovers the hex digits shown on a multiplexed 4-digit 7-segment display by
// sampling its digit selects and segment lines, then publishes complete frames.
module seg_scan_reader #(
   parameter int unsigned STABLE_CNT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  sel,
   input  logic [7:0]  seg,
   output logic [15:0] data_out,
   output logic [3:0]  dp_out,
   output logic [3:0]  err_out,
   output logic        frame_valid
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT - 1);

   logic [3:0]  sel_m, sel_s;
   logic [7:0]  seg_m, seg_s;
   logic [11:0] s_cur, s_prev;
   logic [7:0]  cnt;
   logic        captured;
   logic [3:0]  seen;
   logic [15:0] sh_data;
   logic [3:0]  sh_dp, sh_err;

   logic [3:0]  sel_low;
   logic        s_valid;
   logic        same;
   logic        capture;
   logic [1:0]  dig;
   logic [4:0]  dec;

   // Returns {err, nibble}; the dp bit is deliberately not part of the lookup.
   function automatic logic [4:0] decode(input logic [6:0] code);
      case (code)
         7'h3F:   decode = 5'h00;
         7'h06:   decode = 5'h01;
         7'h5B:   decode = 5'h02;
         7'h4F:   decode = 5'h03;
         7'h66:   decode = 5'h04;
         7'h6D:   decode = 5'h05;
         7'h7D:   decode = 5'h06;
         7'h07:   decode = 5'h07;
         7'h7F:   decode = 5'h08;
         7'h6F:   decode = 5'h09;
         7'h77:   decode = 5'h0A;
         7'h7C:   decode = 5'h0B;
         7'h39:   decode = 5'h0C;
         7'h5E:   decode = 5'h0D;
         7'h79:   decode = 5'h0E;
         7'h71:   decode = 5'h0F;
         default: decode = 5'h10;
      endcase
   endfunction

   always_comb begin
      s_cur   = {sel_s, seg_s};
      sel_low = ~sel_s;
      // Exactly one select low: non-zero and a power of two.
      s_valid = (sel_low != 4'd0) && ((sel_low & (sel_low - 4'd1)) == 4'd0);
      same    = (s_cur == s_prev);
      capture = s_valid && same && !captured && (cnt == CNT_MAX - 8'd1);
      dec     = decode(seg_s[6:0]);
      case (sel_low)
         4'b0010: dig = 2'd1;
         4'b0100: dig = 2'd2;
         4'b1000: dig = 2'd3;
         default: dig = 2'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_m       <= 4'h0;
         sel_s       <= 4'h0;
         seg_m       <= 8'h00;
         seg_s       <= 8'h00;
         s_prev      <= 12'h000;
         cnt         <= 8'd0;
         captured    <= 1'b0;
         seen        <= 4'h0;
         sh_data     <= 16'h0000;
         sh_dp       <= 4'h0;
         sh_err      <= 4'h0;
         data_out    <= 16'h0000;
         dp_out      <= 4'h0;
         err_out     <= 4'h0;
         frame_valid <= 1'b0;
      end else begin
         sel_m  <= sel;
         sel_s  <= sel_m;
         seg_m  <= seg;
         seg_s  <= seg_m;
         s_prev <= s_cur;

         if (!s_valid || !same) begin
            cnt      <= 8'd0;
            captured <= 1'b0;
         end else begin
            if (cnt != CNT_MAX)
               cnt <= cnt + 8'd1;
            if (capture)
               captured <= 1'b1;
         end

         if (capture) begin
            sh_data[{dig, 2'b00} +: 4] <= dec[3:0];
            sh_dp[dig]                 <= seg_s[7];
            sh_err[dig]                <= dec[4];
         end

         // Commit copies the shadow as it stood before any same-cycle capture;
         // that capture then opens the next frame's seen mask.
         if (seen == 4'hF) begin
            data_out    <= sh_data;
            dp_out      <= sh_dp;
            err_out     <= sh_err;
            frame_valid <= 1'b1;
            seen        <= capture ? sel_low : 4'h0;
         end else begin
            frame_valid <= 1'b0;
            if (capture)
               seen <= seen | sel_low;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Randomised and directed bench for seg_scan_reader, checked against a
// run-length model of the display scan.
module tb_seg_scan_reader;

   localparam int SC = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  sel = 4'hF;
   logic [7:0]  seg = 8'h00;
   logic [15:0] data_out;
   logic [3:0]  dp_out;
   logic [3:0]  err_out;
   logic        frame_valid;

   seg_scan_reader #(.STABLE_CNT(SC)) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .seg(seg),
      .data_out(data_out), .dp_out(dp_out), .err_out(err_out),
      .frame_valid(frame_valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int frame_cnt = 0;
   int m_frames = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Model state: current run of identical samples and the frame being built.
   logic [11:0] run_val = 12'h000;
   int          run_len = 0;
   logic [15:0] m_data = 16'h0;
   logic [3:0]  m_dp = 4'h0, m_err = 4'h0, m_seen = 4'h0;
   logic [6:0]  code_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [23:0] exp_q[$];
   int          exp_cyc_q[$];
   logic [23:0] exp_out = 24'h0;
   logic [23:0] got;

   task automatic model_sample(input logic [3:0] s, input logic [7:0] g, input int edge_no);
      int d;
      logic [3:0] onehot;
      logic [3:0] nib;
      logic er;
      d = -1;
      for (int i = 0; i < 4; i++) begin
         onehot = 4'b0001 << i;
         if (s == ~onehot) d = i;
      end
      if (run_len > 0 && {s, g} == run_val) run_len++;
      else begin
         run_val = {s, g};
         run_len = 1;
      end
      if (d >= 0 && run_len == SC) begin
         nib = 4'h0;
         er = 1'b1;
         for (int k = 0; k < 16; k++)
            if (code_tbl[k] == g[6:0]) begin
               nib = 4'(k);
               er = 1'b0;
            end
         m_data[4*d +: 4] = nib;
         m_dp[d] = g[7];
         m_err[d] = er;
         m_seen[d] = 1'b1;
         if (m_seen == 4'hF) begin
            exp_q.push_back({m_data, m_dp, m_err});
            exp_cyc_q.push_back(edge_no + 3);
            m_seen = 4'h0;
            m_frames++;
         end
      end
   endtask

   // Output monitor: frames must arrive on the predicted cycle with the
   // predicted contents, and outputs must hold between frames.
   always @(negedge clk) begin
      if (!rst_n) exp_out = 24'h0;
      else begin
         if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
            errors++;
            checks++;
            $display("FAIL frame_missed: expected pulse at cycle %0d, absent through cycle %0d", exp_cyc_q[0], cyc);
            exp_out = exp_q.pop_front();
            void'(exp_cyc_q.pop_front());
         end
         if (frame_valid) begin
            frame_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
               got = {data_out, dp_out, err_out};
               if (got !== exp_q[0] || cyc != exp_cyc_q[0]) begin
                  errors++;
                  $display("FAIL frame_content: got %h at cycle %0d, expected %h at cycle %0d",
                           got, cyc, exp_q[0], exp_cyc_q[0]);
               end
               exp_out = exp_q.pop_front();
               void'(exp_cyc_q.pop_front());
            end
         end
      end
      checks++;
      if ({data_out, dp_out, err_out} !== exp_out || (!rst_n && frame_valid !== 1'b0)) begin
         errors++;
         $display("FAIL output_hold: got %h fv=%b, expected %h at cycle %0d",
                  {data_out, dp_out, err_out}, frame_valid, exp_out, cyc);
      end
   end

   task automatic step(input logic [3:0] s, input logic [7:0] g);
      sel = s;
      seg = g;
      @(posedge clk);
      #1;
      model_sample(s, g, cyc);
   endtask

   task automatic hold(input logic [3:0] s, input logic [7:0] g, input int n);
      repeat (n) step(s, g);
   endtask

   task automatic idle(input int n);
      hold(4'hF, 8'h00, n);
   endtask

   task automatic scan(input logic [7:0] c0, input logic [7:0] c1,
                       input logic [7:0] c2, input logic [7:0] c3, input int n);
      hold(4'hE, c0, n);
      hold(4'hD, c1, n);
      hold(4'hB, c2, n);
      hold(4'h7, c3, n);
   endtask

   task automatic do_reset();
      idle(4);
      rst_n = 1'b0;
      run_len = 0;
      m_data = 16'h0;
      m_dp = 4'h0;
      m_err = 4'h0;
      m_seen = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({data_out, dp_out, err_out, frame_valid} !== 25'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, expected 0", {data_out, dp_out, err_out, frame_valid});
      end
      rst_n = 1'b1;
      idle(3);
   endtask

   task automatic check_frame(input string name, input int n_frames, input int f0,
                              input logic [15:0] d, input logic [3:0] dp, input logic [3:0] er);
      checks++;
      if (frame_cnt - f0 != n_frames) begin
         errors++;
         $display("FAIL %s_count: got %0d frames, expected %0d", name, frame_cnt - f0, n_frames);
      end
      checks++;
      if ({data_out, dp_out, err_out} !== {d, dp, er}) begin
         errors++;
         $display("FAIL %s_value: got %h/%h/%h, expected %h/%h/%h", name,
                  data_out, dp_out, err_out, d, dp, er);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({data_out, dp_out, err_out, frame_valid} !== 25'h0) begin
         errors++;
         $display("FAIL reset_state: got %h, expected 0", {data_out, dp_out, err_out, frame_valid});
      end
      rst_n = 1'b1;
      idle(3);
   endtask

   task automatic test_basic();
      int f0;
      f0 = frame_cnt;
      scan(8'h06, 8'h5B, 8'h4F, 8'h66, 10);
      idle(6);
      check_frame("basic", 1, f0, 16'h4321, 4'h0, 4'h0);
   endtask

   task automatic test_bad_code();
      int f0;
      f0 = frame_cnt;
      scan(8'h06, 8'h5B, 8'h00, 8'h66, 10);
      idle(6);
      check_frame("bad_code", 1, f0, 16'h4021, 4'h0, 4'b0100);
   endtask

   task automatic test_dp();
      int f0;
      f0 = frame_cnt;
      scan(8'hBF, 8'h5B, 8'h4F, 8'h66, 10);
      idle(6);
      check_frame("dp", 1, f0, 16'h4320, 4'b0001, 4'h0);
   endtask

   task automatic test_glitch();
      int f0;
      f0 = frame_cnt;
      hold(4'hE, 8'h06, 10);
      hold(4'hD, 8'h5B, 3);
      hold(4'hD, 8'h7F, 3);
      hold(4'hD, 8'h5B, 10);
      hold(4'hB, 8'h4F, 10);
      hold(4'b1100, 8'h7F, 10);
      hold(4'h7, 8'h66, 10);
      idle(6);
      check_frame("glitch", 1, f0, 16'h4321, 4'h0, 4'h0);
   endtask

   task automatic test_reset_mid();
      int f0;
      hold(4'hE, 8'h3F, 10);
      hold(4'hD, 8'h3F, 10);
      hold(4'hB, 8'h3F, 10);
      do_reset();
      f0 = frame_cnt;
      hold(4'h7, 8'h66, 10);
      idle(6);
      check_frame("reset_mid_partial", 0, f0, 16'h0000, 4'h0, 4'h0);
      f0 = frame_cnt;
      scan(8'h06, 8'h5B, 8'h4F, 8'h66, 10);
      idle(6);
      check_frame("reset_mid_full", 1, f0, 16'h4321, 4'h0, 4'h0);
   endtask

   task automatic test_long_hold();
      int f0;
      do_reset();
      f0 = frame_cnt;
      hold(4'hE, 8'h3F, 40);
      hold(4'hD, 8'h06, 6);
      hold(4'hB, 8'h5B, 6);
      hold(4'h7, 8'h4F, 40);
      idle(6);
      check_frame("long_hold", 1, f0, 16'h3210, 4'h0, 4'h0);
   endtask

   task automatic test_back_to_back();
      int f0, m0;
      logic [3:0] s, onehot;
      logic [7:0] g;
      f0 = frame_cnt;
      m0 = m_frames;
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 4; i++) begin
            onehot = 4'b0001 << i;
            s = ~onehot;
            if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) g = 8'($urandom_range(0, 255));
            else g = {1'($urandom_range(0, 1)), code_tbl[$urandom_range(0, 15)]};
            hold(s, g, $urandom_range(2, 8));
         end
      end
      idle(8);
      checks++;
      if (frame_cnt - f0 != m_frames - m0) begin
         errors++;
         $display("FAIL back_to_back_count: got %0d frames, expected %0d", frame_cnt - f0, m_frames - m0);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_basic();
      test_bad_code();
      test_dp();
      test_glitch();
      test_reset_mid();
      test_long_hold();
      test_back_to_back();
      idle(10);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL frames_pending: %0d expected frames never seen", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_reader.md
SEG_SCAN_READER -- requirements
Module: seg_scan_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 The block SHALL have parameter STABLE_CNT, default 16, giving the number of consecutive identical samples required before a digit is captured (legal range 2..255).
REQ-003 The block SHALL have these ports, one per line:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- sel  input  4  scanned digit select, active-low, sel[i]=0 enables digit i
- seg  input  8  segment lines, active-high; bit0..bit6 = a..g, bit7 = dp
- data_out  output  16  captured hex values; digit i in data_out[4i+3:4i]
- dp_out  output  4  captured dp per digit
- err_out  output  4  per digit: 1 = segment code not in decode table
- frame_valid  output  1  one-cycle pulse when data_out, dp_out and err_out update

Function
REQ-004 sel and seg SHALL each pass through a 2-flop synchronizer; all further logic uses the synchronized sample S = {sel_s, seg_s}.
REQ-005 S SHALL be valid only when sel_s has exactly one bit low; all-high or multiple-low values are invalid.
REQ-006 A stability counter SHALL clear to 0 when S differs from the previous cycle's S or S is invalid, SHALL otherwise increment, and SHALL saturate at STABLE_CNT-1.
REQ-007 A capture SHALL occur on the edge where the counter reaches STABLE_CNT-1, i.e. after STABLE_CNT consecutive identical valid samples.
REQ-008 At most one capture SHALL occur per stable window; the next capture requires a change of S first.
REQ-009 On capture of digit i, shadow nibble i SHALL be set from seg_s[6:0] using this table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71 (hex codes on seg[6:0]).
REQ-010 On capture, shadow dp i SHALL be set to seg_s[7]; dp SHALL NOT affect decoding.
REQ-011 A code not in the table SHALL give shadow nibble 4'h0 and shadow err i = 1; a code in the table SHALL give err i = 0.
REQ-012 On capture, seen-mask bit i SHALL be set; recapturing a digit already seen SHALL overwrite its shadow entry and SHALL NOT produce an extra pulse.
REQ-013 On the edge after the seen mask first becomes 4'b1111:
- shadow data SHALL copy to data_out, dp_out and err_out in a single cycle;
- frame_valid SHALL be 1 for exactly that one cycle;
- the seen mask SHALL clear.
REQ-014 A capture in the same cycle as a frame commit SHALL be kept in shadow and SHALL set its bit in the cleared seen mask.
REQ-015 Outputs SHALL hold their values between commits.
REQ-016 Latency SHALL be: last digit's S stable → 2 sync cycles + STABLE_CNT cycles to capture → 1 cycle to frame_valid.

Reset
REQ-017 While rst_n=0:
- data_out=16'h0000, dp_out=4'h0, err_out=4'h0, frame_valid=0;
- synchronizers, counter, captured flag, seen mask and shadow registers SHALL clear.
REQ-018 Reset asserted mid-frame SHALL discard partial captures; no frame_valid SHALL occur until all four digits are captured again after reset release.

Verification (STABLE_CNT=4)
REQ-019 Scenario: sel=E/D/B/7 with seg=06/5B/4F/66, each held 10 cycles → one frame_valid; data_out=16'h4321, dp_out=0, err_out=0.
REQ-020 Scenario: as REQ-019 but digit2 seg=8'h00 → data_out=16'h4021, err_out=4'b0100.
REQ-021 Scenario: digit0 seg=8'hBF → nibble 0, dp_out[0]=1, err_out[0]=0.
REQ-022 Scenario: a 3-cycle glitch seg=7F inside digit1's window, or sel=4'b1100 held 10 cycles → no capture from the glitch or invalid sel; data_out unchanged by them.
REQ-023 Scenario: rst_n pulsed low after digits 0–2 are captured → no frame_valid until digits 0–3 are all re-captured; output values are zero until that pulse.
REQ-024 Scenario: a digit held 40 cycles → exactly one capture; continuous scanning → one frame_valid per complete 4-digit scan.
